// File: rtl/iter_seq_control_pkg.sv
//------------------------------------------------------------------------------
// Module  : iter_seq_control_pkg
// Brief   : Shared types and defaults for the iterative-datapath sequencer.
//           Holds the FSM state encoding and the default job geometry used
//           by iter_seq_control and iter_counter.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package iter_seq_control_pkg;

    // Sequencer states: IDLE waits for a job, RUN issues iteration enables.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Default job geometry: 32 iterations, 4-bit job tag.
    localparam int c_n_iter_default = 32;
    localparam int c_tag_w_default  = 4;

endpackage : iter_seq_control_pkg

`default_nettype wire

// File: rtl/iter_seq_control_iter_counter.sv
//------------------------------------------------------------------------------
// Module  : iter_counter
// Brief   : Modulo-N_ITER up-counter with synchronous clear. Provides the
//           iteration index and a flag marking the final iteration.
// Ports   : clock   - system clock, rising edge
//           reset   - synchronous active-high reset (count -> 0)
//           clr     - synchronous clear (count -> 0)
//           inc     - advance the count by one, wrapping at N_ITER-1
//           count   - current iteration index, 0..N_ITER-1
//           at_last - count == N_ITER-1
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module iter_counter #(
    parameter int N_ITER = 32,
    parameter int CNT_W  = $clog2(N_ITER)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_last
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(N_ITER - 1);

    logic [CNT_W-1:0] r_count;

    // Wrap is explicit at N_ITER-1, so non-power-of-two N_ITER never lets
    // the index run past the last iteration.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (inc) begin
            if (r_count == c_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign count   = r_count;
    assign at_last = (r_count == c_last);

endmodule : iter_counter

`default_nettype wire

// File: rtl/iter_seq_control.sv
//------------------------------------------------------------------------------
// Module  : iter_seq_control
// Brief   : Job sequencer for iterative (CORDIC-style) datapaths. Each
//           accepted start runs N_ITER enable cycles, publishes the iteration
//           index with first/last flags and ends with a one-cycle done pulse
//           carrying the job tag. A one-deep pending buffer gives zero-bubble
//           back-to-back jobs; abort cancels running and pending work.
// Ports   : clock, reset          - clock / synchronous active-high reset
//           start, start_tag      - job request and its tag
//           abort                 - synchronous cancel
//           start_ready           - low only while a job is pending
//           enable, iter          - datapath enable and iteration index
//           first, last           - first / last iteration flags
//           run_tag               - tag of the running job
//           done, done_tag        - completion pulse and completed job tag
//           busy                  - running or holding a pending job
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module iter_seq_control
    import iter_seq_control_pkg::*;
#(
    parameter int N_ITER = c_n_iter_default,   // legal range 2..1024
    parameter int TAG_W  = c_tag_w_default
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [TAG_W-1:0]          start_tag,
    input  logic                      abort,
    output logic                      start_ready,
    output logic                      enable,
    output logic [$clog2(N_ITER)-1:0] iter,
    output logic                      first,
    output logic                      last,
    output logic [TAG_W-1:0]          run_tag,
    output logic                      done,
    output logic [TAG_W-1:0]          done_tag,
    output logic                      busy
);

    localparam int CNT_W = $clog2(N_ITER);

    state_t             r_state;
    logic               r_pend_valid;
    logic [TAG_W-1:0]   r_pend_tag;
    logic [TAG_W-1:0]   r_run_tag;
    logic               r_done;
    logic [TAG_W-1:0]   r_done_tag;

    logic               w_running;
    logic               w_accept;
    logic [CNT_W-1:0]   w_count;
    logic               w_at_last;

    assign w_running = (r_state == ST_RUN);
    // Abort wins over a simultaneous start.
    assign w_accept  = start & ~r_pend_valid & ~abort;

    // The counter only advances while running and wraps on the last
    // iteration, so it already sits at zero whenever a new job begins,
    // whether from IDLE, from the pending buffer or through the bypass.
    iter_counter #(
        .N_ITER (N_ITER),
        .CNT_W  (CNT_W)
    ) u_iter_counter (
        .clock   (clock),
        .reset   (reset),
        .clr     (abort),
        .inc     (w_running),
        .count   (w_count),
        .at_last (w_at_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pend_valid <= 1'b0;
            r_pend_tag   <= '0;
            r_run_tag    <= '0;
            r_done       <= 1'b0;
            r_done_tag   <= '0;
        end else if (abort) begin
            r_state      <= ST_IDLE;
            r_pend_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_RUN;
                        r_run_tag <= start_tag;
                    end
                end
                ST_RUN: begin
                    if (w_at_last) begin
                        r_done     <= 1'b1;
                        r_done_tag <= r_run_tag;
                        if (r_pend_valid) begin
                            // Pending job starts immediately: done and first
                            // land on the same cycle.
                            r_run_tag    <= r_pend_tag;
                            r_pend_valid <= 1'b0;
                        end else if (w_accept) begin
                            // Start arriving on the last cycle bypasses the
                            // pending buffer.
                            r_run_tag <= start_tag;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_accept) begin
                        r_pend_tag   <= start_tag;
                        r_pend_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = ~r_pend_valid;
    assign enable      = w_running;
    assign iter        = w_count;
    assign first       = w_running & (w_count == '0);
    assign last        = w_running & w_at_last;
    assign run_tag     = r_run_tag;
    assign done        = r_done;
    assign done_tag    = r_done_tag;
    assign busy        = w_running | r_pend_valid;

endmodule : iter_seq_control

`default_nettype wire

// File: tb/tb_iter_seq_control.sv
//------------------------------------------------------------------------------
// Module  : tb_iter_seq_control
// Brief   : Self-checking bench for iter_seq_control. Two instances (N_ITER=32
//           and N_ITER=5) share one directed stimulus stream; a timeline model
//           predicts every output each cycle, and literal expectations pin the
//           key scenario timings.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iter_seq_control;

    localparam int N_A = 32;
    localparam int N_B = 5;
    localparam int TW  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [TW-1:0] start_tag = '0;

    logic          start_ready_a, enable_a, first_a, last_a, done_a, busy_a;
    logic [4:0]    iter_a;
    logic [TW-1:0] run_tag_a, done_tag_a;
    logic          start_ready_b, enable_b, first_b, last_b, done_b, busy_b;
    logic [2:0]    iter_b;
    logic [TW-1:0] run_tag_b, done_tag_b;

    iter_seq_control #(.N_ITER(N_A), .TAG_W(TW)) dut_a (
        .clock(clock), .reset(reset), .start(start), .start_tag(start_tag),
        .abort(abort), .start_ready(start_ready_a), .enable(enable_a),
        .iter(iter_a), .first(first_a), .last(last_a), .run_tag(run_tag_a),
        .done(done_a), .done_tag(done_tag_a), .busy(busy_a)
    );

    iter_seq_control #(.N_ITER(N_B), .TAG_W(TW)) dut_b (
        .clock(clock), .reset(reset), .start(start), .start_tag(start_tag),
        .abort(abort), .start_ready(start_ready_b), .enable(enable_b),
        .iter(iter_b), .first(first_b), .last(last_b), .run_tag(run_tag_b),
        .done(done_b), .done_tag(done_tag_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    // Timeline model: a running job is described by the cycle on which its
    // iteration 0 is visible; the index is simply elapsed cycles since then.
    typedef struct {
        bit rv;   // a job is running
        int rs;   // cycle on which its iteration 0 is visible
        int rt;   // its tag
        bit pv;   // a job is pending
        int pt;   // pending tag
        int da;   // cycle on which done must be high (-1: none)
        int dt;   // tag expected with that done
    } mdl_t;

    mdl_t ma = '{0, 0, 0, 0, 0, -1, 0};
    mdl_t mb = '{0, 0, 0, 0, 0, -1, 0};
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    bit   chk_on = 1'b0;

    // Next-cycle model from the inputs seen at the end of cycle 'now'.
    function automatic mdl_t step(input mdl_t m, input int now, input int nit,
                                  input bit rst, input bit st, input int tag,
                                  input bit ab);
        mdl_t r = m;
        bit   acc;
        bit   is_last;
        is_last = m.rv && (now - m.rs == nit - 1);
        acc     = st && !m.pv;
        if (rst) begin
            r = '{0, 0, 0, 0, 0, -1, 0};
        end else if (ab) begin
            r.rv = 0;
            r.pv = 0;
        end else if (is_last) begin
            r.da = now + 1;
            r.dt = m.rt;
            if (m.pv) begin
                r.rs = now + 1; r.rt = m.pt; r.pv = 0;
            end else if (acc) begin
                r.rs = now + 1; r.rt = tag;
            end else begin
                r.rv = 0;
            end
        end else if (!m.rv) begin
            if (acc) begin
                r.rv = 1; r.rs = now + 1; r.rt = tag;
            end
        end else if (acc) begin
            r.pv = 1; r.pt = tag;
        end
        return r;
    endfunction

    always @(posedge clock) begin
        ma  = step(ma, cyc, N_A, reset, start, int'(start_tag), abort);
        mb  = step(mb, cyc, N_B, reset, start, int'(start_tag), abort);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp(input string p, input mdl_t m, input int nit,
                       input logic sr, input logic en, input logic [31:0] it,
                       input logic fi, input logic la, input logic [31:0] rt,
                       input logic dn, input logic [31:0] dt, input logic bs);
        int ei = m.rv ? (cyc - m.rs) : 0;
        chk({p, ".enable"},      32'(en), 32'(m.rv));
        chk({p, ".iter"},        it,      32'(ei));
        chk({p, ".first"},       32'(fi), 32'(m.rv && ei == 0));
        chk({p, ".last"},        32'(la), 32'(m.rv && ei == nit - 1));
        chk({p, ".start_ready"}, 32'(sr), 32'(!m.pv));
        chk({p, ".busy"},        32'(bs), 32'(m.rv || m.pv));
        chk({p, ".done"},        32'(dn), 32'(m.da == cyc));
        if (m.da == cyc) chk({p, ".done_tag"}, dt, 32'(m.dt));
        if (m.rv)        chk({p, ".run_tag"},  rt, 32'(m.rt));
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            cmp("a", ma, N_A, start_ready_a, enable_a, 32'(iter_a), first_a, last_a,
                32'(run_tag_a), done_a, 32'(done_tag_a), busy_a);
            cmp("b", mb, N_B, start_ready_b, enable_b, 32'(iter_b), first_b, last_b,
                32'(run_tag_b), done_b, 32'(done_tag_b), busy_b);
        end
    end

    // Returns at the falling edge inside cycle t.
    task automatic go_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic pulse_start(input int t, input int tag);
        go_to(t);
        start     = 1'b1;
        start_tag = TW'(tag);
        go_to(t + 1);
        start     = 1'b0;
    endtask

    initial begin
        // Reset held over two rising edges.
        go_to(1);
        chk_on = 1'b1;
        go_to(2);
        reset = 1'b0;
        go_to(3);
        chk("lit.reset.busy",        32'(busy_a),        32'd0);
        chk("lit.reset.start_ready", 32'(start_ready_a), 32'd1);
        chk("lit.reset.enable",      32'(enable_a),      32'd0);

        // Single job, tag 5, on both instances.
        pulse_start(10, 5);
        chk("lit.single.first",   32'(first_a),   32'd1);
        chk("lit.single.run_tag", 32'(run_tag_a), 32'd5);
        go_to(15);
        chk("lit.n5.last",     32'(last_b), 32'd1);
        chk("lit.n5.iter4",    32'(iter_b), 32'd4);
        go_to(16);
        chk("lit.n5.done",     32'(done_b),     32'd1);
        chk("lit.n5.done_tag", 32'(done_tag_b), 32'd5);
        go_to(42);
        chk("lit.single.last",   32'(last_a), 32'd1);
        chk("lit.single.iter31", 32'(iter_a), 32'd31);
        go_to(43);
        chk("lit.single.done",     32'(done_a),     32'd1);
        chk("lit.single.done_tag", 32'(done_tag_a), 32'd5);
        chk("lit.single.busy",     32'(busy_a),     32'd0);
        go_to(44);
        chk("lit.single.done_off", 32'(done_a), 32'd0);

        // Back-to-back through the pending buffer, plus a start while full.
        pulse_start(60, 1);
        pulse_start(70, 2);
        chk("lit.b2b.start_ready", 32'(start_ready_a), 32'd0);
        pulse_start(80, 9);
        chk("lit.full.start_ready", 32'(start_ready_a), 32'd0);
        go_to(93);
        chk("lit.b2b.done1",    32'(done_a),     32'd1);
        chk("lit.b2b.dtag1",    32'(done_tag_a), 32'd1);
        chk("lit.b2b.first2",   32'(first_a),    32'd1);
        chk("lit.b2b.run_tag2", 32'(run_tag_a),  32'd2);
        go_to(125);
        chk("lit.b2b.done2", 32'(done_a),     32'd1);
        chk("lit.b2b.dtag2", 32'(done_tag_a), 32'd2);

        // Bypass: start lands exactly on the last iteration.
        pulse_start(140, 3);
        go_to(172);
        chk("lit.bypass.last", 32'(last_a), 32'd1);
        pulse_start(172, 7);
        chk("lit.bypass.done",    32'(done_a),     32'd1);
        chk("lit.bypass.dtag",    32'(done_tag_a), 32'd3);
        chk("lit.bypass.iter0",   32'(iter_a),     32'd0);
        chk("lit.bypass.run_tag", 32'(run_tag_a),  32'd7);
        go_to(205);
        chk("lit.bypass.done7", 32'(done_tag_a), 32'd7);

        // Abort mid-job with a pending job and a simultaneous start.
        pulse_start(220, 4);
        pulse_start(225, 6);
        go_to(236);
        chk("lit.abort.iter15", 32'(iter_a), 32'd15);
        abort = 1'b1; start = 1'b1; start_tag = 4'd8;
        go_to(237);
        abort = 1'b0; start = 1'b0;
        chk("lit.abort.busy",        32'(busy_a),        32'd0);
        chk("lit.abort.done",        32'(done_a),        32'd0);
        chk("lit.abort.start_ready", 32'(start_ready_a), 32'd1);
        go_to(240);
        chk("lit.abort.no_start", 32'(enable_a), 32'd0);

        // Abort on the last iteration: no done.
        pulse_start(250, 10);
        go_to(282);
        chk("lit.abort_last.last", 32'(last_a), 32'd1);
        abort = 1'b1;
        go_to(283);
        abort = 1'b0;
        chk("lit.abort_last.done", 32'(done_a), 32'd0);
        chk("lit.abort_last.busy", 32'(busy_a), 32'd0);

        // Reset mid-job, then a clean job three cycles later.
        pulse_start(300, 11);
        go_to(321);
        chk("lit.rst.iter20", 32'(iter_a), 32'd20);
        reset = 1'b1;
        go_to(322);
        reset = 1'b0;
        chk("lit.rst.enable",   32'(enable_a),   32'd0);
        chk("lit.rst.run_tag",  32'(run_tag_a),  32'd0);
        chk("lit.rst.done_tag", 32'(done_tag_a), 32'd0);
        pulse_start(324, 12);
        chk("lit.rst.first",   32'(first_a),   32'd1);
        chk("lit.rst.run_tag12", 32'(run_tag_a), 32'd12);
        go_to(357);
        chk("lit.rst.done",  32'(done_a),     32'd1);
        chk("lit.rst.dtag",  32'(done_tag_a), 32'd12);

        // N_ITER=5 single job: index wraps at 4.
        pulse_start(370, 5);
        go_to(375);
        chk("lit.n5b.iter4", 32'(iter_b), 32'd4);
        go_to(376);
        chk("lit.n5b.done", 32'(done_b), 32'd1);
        go_to(380);
        chk("lit.n5b.idle", 32'(enable_b), 32'd0);

        go_to(410);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_iter_seq_control

`default_nettype wire
